// File: rtl/regfile_writeback_if.sv
// Issue, producer handshake, scoreboard lookup and register-file write port
// bundle for the writeback stage.
interface regfile_writeback_if;
    logic        IssueValid;
    logic [3:0]  IssueReg;
    logic        IssueStall;
    logic        AluValid;
    logic [3:0]  AluReg;
    logic [15:0] AluData;
    logic        AluReady;
    logic        LdValid;
    logic [3:0]  LdReg;
    logic [15:0] LdData;
    logic        LdReady;
    logic [3:0]  ChkReg1;
    logic [3:0]  ChkReg2;
    logic        Busy1;
    logic        Busy2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;

    modport master (
        output IssueValid, IssueReg, AluValid, AluReg, AluData,
               LdValid, LdReg, LdData, ChkReg1, ChkReg2,
        input  IssueStall, AluReady, LdReady, Busy1, Busy2,
               DstReg, WriteReg, DstData
    );

    modport slave (
        input  IssueValid, IssueReg, AluValid, AluReg, AluData,
               LdValid, LdReg, LdData, ChkReg1, ChkReg2,
        output IssueStall, AluReady, LdReady, Busy1, Busy2,
               DstReg, WriteReg, DstData
    );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback arbiter: ALU results win, loads queue behind them in a small FIFO,
// and a pending-destination scoreboard stalls write-after-write issues.
module regfile_writeback #(
    parameter int LQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    regfile_writeback_if.slave bus
);
    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = $clog2(LQ_DEPTH + 1);

    logic [LQ_DEPTH-1:0][3:0]  r_lq_reg;
    logic [LQ_DEPTH-1:0][15:0] r_lq_data;
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;
    logic [15:0]               r_pending;
    logic [3:0]                r_dst_reg;
    logic [15:0]               r_dst_data;
    logic                      r_wr;

    logic        w_full;
    logic        w_nonempty;
    logic        w_alu_acc;
    logic        w_ld_acc;
    logic        w_pop;
    logic        w_push;
    logic        w_sel;
    logic [3:0]  w_sel_reg;
    logic [15:0] w_sel_data;
    logic        w_issue_ok;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [15:0] w_pending_nxt;

    assign w_full     = (r_count == CW'(LQ_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_alu_acc  = bus.AluValid & ~w_full;
    assign w_ld_acc   = bus.LdValid & ~w_full;

    assign bus.AluReady   = ~w_full;
    assign bus.LdReady    = ~w_full;
    assign bus.IssueStall = bus.IssueValid & r_pending[bus.IssueReg];
    assign bus.Busy1      = r_pending[bus.ChkReg1];
    assign bus.Busy2      = r_pending[bus.ChkReg2];
    assign bus.DstReg     = r_dst_reg;
    assign bus.DstData    = r_dst_data;
    assign bus.WriteReg   = r_wr;

    // A load only skips the queue when nothing older or higher-priority exists.
    always_comb begin
        w_sel      = 1'b0;
        w_sel_reg  = 4'h0;
        w_sel_data = 16'h0000;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        if (w_alu_acc) begin
            w_sel      = 1'b1;
            w_sel_reg  = bus.AluReg;
            w_sel_data = bus.AluData;
            w_push     = w_ld_acc;
        end else if (w_nonempty) begin
            w_sel      = 1'b1;
            w_pop      = 1'b1;
            w_sel_reg  = r_lq_reg[r_rptr];
            w_sel_data = r_lq_data[r_rptr];
            w_push     = w_ld_acc;
        end else if (w_ld_acc) begin
            w_sel      = 1'b1;
            w_sel_reg  = bus.LdReg;
            w_sel_data = bus.LdData;
        end
    end

    assign w_issue_ok    = bus.IssueValid & ~bus.IssueStall & (bus.IssueReg != 4'h0);
    assign w_set         = w_issue_ok ? (16'h0001 << bus.IssueReg) : 16'h0000;
    assign w_clr         = w_sel ? (16'h0001 << w_sel_reg) : 16'h0000;
    assign w_pending_nxt = ((r_pending & ~w_clr) | w_set) & 16'hFFFE;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lq_reg[r_wptr]  <= bus.LdReg;
            r_lq_data[r_wptr] <= bus.LdData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pending  <= 16'h0000;
            r_dst_reg  <= 4'h0;
            r_dst_data <= 16'h0000;
            r_wr       <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_pending <= w_pending_nxt;
            r_wr      <= w_sel & (w_sel_reg != 4'h0);
            if (w_sel) begin
                r_dst_reg  <= w_sel_reg;
                r_dst_data <= w_sel_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed table of per-cycle vectors for the writeback stage, followed by a
// hand-written mid-operation reset sequence.
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    regfile_writeback_if bus();

    regfile_writeback #(.LQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;  logic [3:0] ir;
        logic        av;  logic [3:0] ar;  logic [15:0] ad;
        logic        lv;  logic [3:0] lr;  logic [15:0] ld;
        logic [3:0]  c1;  logic [3:0] c2;
        logic        st;  logic ardy; logic lrdy; logic b1; logic b2;
        logic        wr;  logic [3:0] dr;  logic [15:0] dd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic iv, logic [3:0] ir, logic av, logic [3:0] ar, logic [15:0] ad,
        logic lv, logic [3:0] lr, logic [15:0] ld, logic [3:0] c1, logic [3:0] c2,
        logic st, logic ardy, logic lrdy, logic b1, logic b2,
        logic wr, logic [3:0] dr, logic [15:0] dd);
        vec_t v;
        v.iv = iv; v.ir = ir; v.av = av; v.ar = ar; v.ad = ad;
        v.lv = lv; v.lr = lr; v.ld = ld; v.c1 = c1; v.c2 = c2;
        v.st = st; v.ardy = ardy; v.lrdy = lrdy; v.b1 = b1; v.b2 = b2;
        v.wr = wr; v.dr = dr; v.dd = dd;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.IssueValid = v.iv; bus.IssueReg = v.ir;
        bus.AluValid = v.av; bus.AluReg = v.ar; bus.AluData = v.ad;
        bus.LdValid = v.lv; bus.LdReg = v.lr; bus.LdData = v.ld;
        bus.ChkReg1 = v.c1; bus.ChkReg2 = v.c2;
    endtask

    task automatic compare(input int row, input vec_t v);
        chk("IssueStall", row, {15'h0, bus.IssueStall}, {15'h0, v.st});
        chk("AluReady",   row, {15'h0, bus.AluReady},   {15'h0, v.ardy});
        chk("LdReady",    row, {15'h0, bus.LdReady},    {15'h0, v.lrdy});
        chk("Busy1",      row, {15'h0, bus.Busy1},      {15'h0, v.b1});
        chk("Busy2",      row, {15'h0, bus.Busy2},      {15'h0, v.b2});
        chk("WriteReg",   row, {15'h0, bus.WriteReg},   {15'h0, v.wr});
        chk("DstReg",     row, {12'h0, bus.DstReg},     {12'h0, v.dr});
        chk("DstData",    row, bus.DstData,             v.dd);
    endtask

    task automatic step(input int row, input vec_t v, input logic do_cmp);
        @(negedge clk);
        drive(v);
        #1;
        if (do_cmp) compare(row, v);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = mk(0,0, 0,0,0, 0,0,0, 0,0, 0,1,1,0,0, 0,0,0);
        drive(idle);

        //      iv ir  av ar ad        lv lr ld        c1 c2  st ar lr b1 b2  wr dr dd
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 3,0,  0,1,1,0,0,  0,0, 16'h0000));
        tbl.push_back(mk(1,3,  0,0, 16'h0000, 0,0,16'h0000, 3,0,  0,1,1,0,0,  0,0, 16'h0000));
        tbl.push_back(mk(0,0,  1,3, 16'h1234, 0,0,16'h0000, 3,0,  0,1,1,1,0,  0,0, 16'h0000));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 3,0,  0,1,1,0,0,  1,3, 16'h1234));
        tbl.push_back(mk(0,0,  1,1, 16'hAAAA, 1,2,16'h5555, 1,2,  0,1,1,0,0,  0,3, 16'h1234));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,1, 16'hAAAA));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,2, 16'h5555));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  0,2, 16'h5555));
        tbl.push_back(mk(0,0,  1,10,16'h000A, 1,4,16'h0004, 0,0,  0,1,1,0,0,  0,2, 16'h5555));
        tbl.push_back(mk(0,0,  1,11,16'h000B, 1,5,16'h0005, 0,0,  0,1,1,0,0,  1,10,16'h000A));
        tbl.push_back(mk(0,0,  1,12,16'h000C, 1,6,16'h0006, 0,0,  0,1,1,0,0,  1,11,16'h000B));
        tbl.push_back(mk(0,0,  1,13,16'h000D, 1,7,16'h0007, 0,0,  0,1,1,0,0,  1,12,16'h000C));
        tbl.push_back(mk(0,0,  1,14,16'h000E, 0,0,16'h0000, 0,0,  0,0,0,0,0,  1,13,16'h000D));
        tbl.push_back(mk(0,0,  1,14,16'h000E, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,4, 16'h0004));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,14,16'h000E));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,5, 16'h0005));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,6, 16'h0006));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  1,7, 16'h0007));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 0,0,  0,1,1,0,0,  0,7, 16'h0007));
        tbl.push_back(mk(0,0,  1,0, 16'hFFFF, 0,0,16'h0000, 0,0,  0,1,1,0,0,  0,7, 16'h0007));
        tbl.push_back(mk(1,9,  0,0, 16'h0000, 0,0,16'h0000, 9,0,  0,1,1,0,0,  0,0, 16'hFFFF));
        tbl.push_back(mk(1,9,  0,0, 16'h0000, 0,0,16'h0000, 9,0,  1,1,1,1,0,  0,0, 16'hFFFF));
        tbl.push_back(mk(1,9,  1,9, 16'h0909, 0,0,16'h0000, 9,0,  1,1,1,1,0,  0,0, 16'hFFFF));
        tbl.push_back(mk(1,9,  0,0, 16'h0000, 0,0,16'h0000, 9,0,  0,1,1,0,0,  1,9, 16'h0909));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 9,0,  0,1,1,1,0,  0,9, 16'h0909));
        tbl.push_back(mk(1,5,  1,5, 16'h0055, 0,0,16'h0000, 5,9,  0,1,1,0,1,  0,9, 16'h0909));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 5,9,  0,1,1,1,1,  1,5, 16'h0055));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 1,6,16'h0066, 6,0,  0,1,1,0,0,  0,5, 16'h0055));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 6,0,  0,1,1,0,0,  1,6, 16'h0066));
        tbl.push_back(mk(0,0,  0,0, 16'h0000, 0,0,16'h0000, 6,0,  0,1,1,0,0,  0,6, 16'h0066));

        // Outputs while held in reset, then release on a falling edge.
        repeat (2) @(negedge clk);
        #1;
        compare(-1, idle);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) step(i, tbl[i], 1'b1);

        // Three loads queued behind back-to-back ALU results, then reset.
        step(100, mk(1,12, 1,1,16'h0011, 1,2,16'h0022, 0,0, 0,1,1,0,0, 0,0,0), 1'b0);
        step(101, mk(0,0,  1,3,16'h0033, 1,4,16'h0044, 0,0, 0,1,1,0,0, 0,0,0), 1'b0);
        step(102, mk(0,0,  1,5,16'h0055, 1,6,16'h0066, 0,0, 0,1,1,0,0, 0,0,0), 1'b0);
        v = mk(0,0, 0,0,0, 0,0,0, 12,9, 0,1,1,1,1, 1,5,16'h0055);
        step(103, v, 1'b1);
        rst = 1'b0;
        #1;
        v = mk(0,0, 0,0,0, 0,0,0, 12,9, 0,1,1,0,0, 0,0,16'h0000);
        compare(104, v);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) step(105 + k, v, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
